// File: rtl/corefft_strm_axis_outbuf.sv
`default_nettype none
// ============================================================================
// Module   : corefft_strm_axis_outbuf
// Purpose  : Output buffer that sits after the streaming FFT core. It captures
//            each FFT output frame, which has no backpressure, and replays it
//            as a flow-controlled AXI4-Stream master with a per-frame TLAST.
//            Lost samples and truncated frames are reported on sticky flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK          in   1                 single clock
//   RST          in   1                 synchronous active-high reset
//   DATAO_RE     in   DATAO_BITS        FFT real output (signed)
//   DATAO_IM     in   DATAO_BITS        FFT imaginary output (signed)
//   DATAO_VALID  in   1                 FFT output strobe, high for a frame
//   M_TVALID     out  1                 AXI4S valid
//   M_TREADY     in   1                 AXI4S ready
//   M_TDATA      out  2*AXI4S_OUT_DATA  {IM sign-extended, RE sign-extended}
//   M_TLAST      out  1                 last sample of an FFT frame
//   LEVEL        out  log2(DEPTH)+1     stored samples incl. the output stage
//   DROP_FLAG    out  1                 sticky: sample lost on a full FIFO
//   SHORT_FLAG   out  1                 sticky: DATAO_VALID fell mid-frame
// ============================================================================
module corefft_strm_axis_outbuf #(
  parameter int FFT_SIZE       = 256,
  parameter int DATAO_BITS     = 18,
  parameter int AXI4S_OUT_DATA = 24,
  parameter int DEPTH          = 512
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATAO_BITS-1:0]         DATAO_RE,
  input  logic [DATAO_BITS-1:0]         DATAO_IM,
  input  logic                          DATAO_VALID,
  output logic                          M_TVALID,
  input  logic                          M_TREADY,
  output logic [2*AXI4S_OUT_DATA-1:0]   M_TDATA,
  output logic                          M_TLAST,
  output logic [$clog2(DEPTH):0]        LEVEL,
  output logic                          DROP_FLAG,
  output logic                          SHORT_FLAG
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(FFT_SIZE);
  localparam int c_WORD_W = 2*DATAO_BITS + 1;   // {last, IM, RE}

  // Storage and pointers
  logic [c_WORD_W-1:0] r_mem [DEPTH];
  logic [c_WORD_W-1:0] r_ram_q;
  logic [c_WORD_W-1:0] r_byp_word;
  logic                r_byp_sel;
  logic [c_ADDR_W:0]   r_wr_ptr;
  logic [c_ADDR_W:0]   r_rd_ptr;
  logic [c_ADDR_W:0]   r_level;
  logic                r_tvalid;
  logic [c_CNT_W-1:0]  r_in_cnt;
  logic                r_drop;
  logic                r_short;

  logic                w_full;
  logic                w_rd_en;
  logic                w_wr_en;
  logic                w_drop;
  logic                w_last;
  logic                w_byp;
  logic [c_WORD_W-1:0] w_wr_word;
  logic [c_WORD_W-1:0] w_head;
  logic [c_ADDR_W:0]   w_wr_ptr_nxt;
  logic [c_ADDR_W:0]   w_rd_ptr_nxt;
  logic signed [AXI4S_OUT_DATA-1:0] w_re_ext;
  logic signed [AXI4S_OUT_DATA-1:0] w_im_ext;

  // Occupancy counts the head entry too, so full means DEPTH samples in total.
  assign w_full = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                  (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

  assign w_rd_en = r_tvalid && M_TREADY;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr_en = DATAO_VALID && (!w_full || w_rd_en);
  assign w_drop  = DATAO_VALID && w_full && !w_rd_en;

  assign w_last    = (r_in_cnt == c_CNT_W'(FFT_SIZE-1));
  assign w_wr_word = {w_last, DATAO_IM, DATAO_RE};

  assign w_wr_ptr_nxt = w_wr_en ? r_wr_ptr + 1'b1 : r_wr_ptr;
  assign w_rd_ptr_nxt = w_rd_en ? r_rd_ptr + 1'b1 : r_rd_ptr;

  // The RAM is read ahead at the next head address, so its registered output
  // is the AXI output stage. When the entry being written is that same next
  // head, the RAM would return stale data, so the write word is forwarded.
  assign w_byp = w_wr_en && (r_wr_ptr == w_rd_ptr_nxt);

  // Simple dual-port RAM, synchronous read-first
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_wr_word;
    end
    r_ram_q <= r_mem[w_rd_ptr_nxt[c_ADDR_W-1:0]];
  end

  // Forwarded word; only consulted the cycle after a bypass, after which the
  // RAM read of the same address returns the written data.
  always_ff @(posedge CLK) begin
    if (w_byp) begin
      r_byp_word <= w_wr_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_tvalid  <= 1'b0;
      r_byp_sel <= 1'b0;
      r_in_cnt  <= '0;
      r_drop    <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_level   <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      r_tvalid  <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
      r_byp_sel <= w_byp;

      // Frame position keeps running through drops to keep TLAST aligned.
      if (DATAO_VALID) begin
        r_in_cnt <= r_in_cnt + 1'b1;
      end else begin
        r_in_cnt <= '0;
        if (r_in_cnt != '0) begin
          r_short <= 1'b1;
        end
      end

      if (w_drop) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign w_head   = r_byp_sel ? r_byp_word : r_ram_q;
  assign w_re_ext = AXI4S_OUT_DATA'($signed(w_head[DATAO_BITS-1:0]));
  assign w_im_ext = AXI4S_OUT_DATA'($signed(w_head[2*DATAO_BITS-1:DATAO_BITS]));

  // Data is forced to zero while idle so the outputs read 0 out of reset.
  assign M_TVALID   = r_tvalid;
  assign M_TDATA    = r_tvalid ? {w_im_ext, w_re_ext} : '0;
  assign M_TLAST    = r_tvalid & w_head[c_WORD_W-1];
  assign LEVEL      = r_level;
  assign DROP_FLAG  = r_drop;
  assign SHORT_FLAG = r_short;

endmodule
`default_nettype wire

// File: tb/tb_corefft_strm_axis_outbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_corefft_strm_axis_outbuf
// Purpose  : Self-checking bench for corefft_strm_axis_outbuf. A queue model
//            of the buffer tracks expected contents, occupancy and flags every
//            cycle; scenario tasks check beat counts and TLAST placement.
// Revision : 1.0 - initial release
// ============================================================================
module tb_corefft_strm_axis_outbuf;

  localparam int FFT_SIZE = 16;
  localparam int DEPTH    = 32;
  localparam int DB       = 18;
  localparam int AD       = 24;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [DB-1:0]   DATAO_RE = '0;
  logic [DB-1:0]   DATAO_IM = '0;
  logic            DATAO_VALID = 1'b0;
  logic            M_TREADY = 1'b0;
  logic            M_TVALID;
  logic [2*AD-1:0] M_TDATA;
  logic            M_TLAST;
  logic [LW-1:0]   LEVEL;
  logic            DROP_FLAG;
  logic            SHORT_FLAG;

  corefft_strm_axis_outbuf #(
    .FFT_SIZE(FFT_SIZE), .DATAO_BITS(DB), .AXI4S_OUT_DATA(AD), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST),
    .DATAO_RE(DATAO_RE), .DATAO_IM(DATAO_IM), .DATAO_VALID(DATAO_VALID),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
    .M_TLAST(M_TLAST), .LEVEL(LEVEL), .DROP_FLAG(DROP_FLAG),
    .SHORT_FLAG(SHORT_FLAG)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is a bounded queue of {last, TDATA} beats.
  logic [2*AD:0] m_q[$];
  logic [2*AD:0] beat_log[$];
  int            m_cnt = 0;
  int            m_pushes = 0;
  bit            m_drop = 1'b0;
  bit            m_short = 1'b0;
  bit            m_ok = 1'b0;

  function automatic logic [AD-1:0] sext(input logic [DB-1:0] x);
    return {{(AD-DB){x[DB-1]}}, x};
  endfunction

  // Inputs change just after posedge, so at negedge both the DUT state and
  // the inputs for the coming edge are stable.
  always @(negedge CLK) begin : monitor
    bit            pop;
    bit            full;
    logic [2*AD:0] e;
    if (m_ok) begin
      checks++;
      if (M_TVALID !== (m_q.size() != 0)) begin
        errors++;
        $display("FAIL tvalid t=%0t: got %b want %b", $time, M_TVALID, (m_q.size() != 0));
      end
      checks++;
      if (LEVEL !== LW'(m_q.size())) begin
        errors++;
        $display("FAIL level t=%0t: got %0d want %0d", $time, LEVEL, m_q.size());
      end
      checks++;
      if (DROP_FLAG !== m_drop) begin
        errors++;
        $display("FAIL drop_flag t=%0t: got %b want %b", $time, DROP_FLAG, m_drop);
      end
      checks++;
      if (SHORT_FLAG !== m_short) begin
        errors++;
        $display("FAIL short_flag t=%0t: got %b want %b", $time, SHORT_FLAG, m_short);
      end
      if (m_q.size() != 0) begin
        checks++;
        if ({M_TLAST, M_TDATA} !== m_q[0]) begin
          errors++;
          $display("FAIL head_beat t=%0t: got last=%b data=%h want last=%b data=%h",
                   $time, M_TLAST, M_TDATA, m_q[0][2*AD], m_q[0][2*AD-1:0]);
        end
      end
    end

    if (RST) begin
      m_q.delete();
      m_cnt   = 0;
      m_drop  = 1'b0;
      m_short = 1'b0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      full = (m_q.size() == DEPTH);
      pop  = (m_q.size() != 0) && M_TREADY;
      if (pop) begin
        beat_log.push_back({M_TLAST, M_TDATA});
        void'(m_q.pop_front());
      end
      if (DATAO_VALID) begin
        e = {(m_cnt == FFT_SIZE-1), sext(DATAO_IM), sext(DATAO_RE)};
        if (!full || pop) begin
          m_q.push_back(e);
          m_pushes++;
        end else begin
          m_drop = 1'b1;
        end
        m_cnt = (m_cnt + 1) % FFT_SIZE;
      end else begin
        if (m_cnt != 0) m_short = 1'b1;
        m_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    DATAO_VALID = 1'b0;
    M_TREADY = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic send(input int n, input bit ramp, input bit toggle);
    for (int i = 0; i < n; i++) begin
      DATAO_VALID = 1'b1;
      DATAO_RE = ramp ? DB'(i)  : DB'($urandom);
      DATAO_IM = ramp ? DB'(-i) : DB'($urandom);
      if (toggle) M_TREADY = ~M_TREADY;
      step();
    end
    DATAO_VALID = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int bound);
    bit done;
    done = 1'b0;
    DATAO_VALID = 1'b0;
    if (!toggle) M_TREADY = 1'b1;
    for (int n = 0; n < bound; n++) begin
      if (toggle) M_TREADY = ~M_TREADY;
      step();
      if (LEVEL == 0 && !M_TVALID) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got level=%0d after %0d cycles want 0", LEVEL, bound);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DATAO_VALID = 1'b1;
    DATAO_RE = DB'($urandom);
    DATAO_IM = DB'($urandom);
    M_TREADY = 1'b1;
    step();
    step();
    checks++;
    if ({M_TVALID, M_TLAST, DROP_FLAG, SHORT_FLAG} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_bits: got tvalid=%b tlast=%b drop=%b short=%b want 0",
               M_TVALID, M_TLAST, DROP_FLAG, SHORT_FLAG);
    end
    checks++;
    if (M_TDATA !== '0) begin
      errors++;
      $display("FAIL reset_tdata: got %h want 0", M_TDATA);
    end
    checks++;
    if (LEVEL !== '0) begin
      errors++;
      $display("FAIL reset_level: got %0d want 0", LEVEL);
    end
    DATAO_VALID = 1'b0;
    M_TREADY = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [AD-1:0] im_lane;
    logic [2*AD:0] exp;
    do_reset();
    beat_log.delete();
    M_TREADY = 1'b1;
    send(FFT_SIZE, 1'b1, 1'b0);
    drain(1'b0, 100);
    checks++;
    if (beat_log.size() != FFT_SIZE) begin
      errors++;
      $display("FAIL single_count: got %0d beats want %0d", beat_log.size(), FFT_SIZE);
    end
    for (int k = 0; k < FFT_SIZE && k < beat_log.size(); k++) begin
      im_lane = 24'hFFFFFF - AD'(k) + 24'd1;
      exp = {(k == FFT_SIZE-1), im_lane, AD'(k)};
      checks++;
      if (beat_log[k] !== exp) begin
        errors++;
        $display("FAIL single_beat%0d: got %h want %h", k, beat_log[k], exp);
      end
    end
    checks++;
    if (DROP_FLAG !== 1'b0 || SHORT_FLAG !== 1'b0) begin
      errors++;
      $display("FAIL single_flags: got drop=%b short=%b want 0 0", DROP_FLAG, SHORT_FLAG);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(2*FFT_SIZE, 1'b0, 1'b0);
    step();
    checks++;
    if (LEVEL !== LW'(32) || DROP_FLAG !== 1'b0 || SHORT_FLAG !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fill: got level=%0d drop=%b short=%b want 32 0 0",
               LEVEL, DROP_FLAG, SHORT_FLAG);
    end
    beat_log.delete();
    drain(1'b0, 100);
    checks++;
    if (beat_log.size() != 32) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 32", beat_log.size());
    end
    for (int i = 0; i < beat_log.size(); i++) begin
      checks++;
      if (beat_log[i][2*AD] !== (i == 15 || i == 31)) begin
        errors++;
        $display("FAIL b2b_tlast%0d: got %b want %b", i, beat_log[i][2*AD], (i == 15 || i == 31));
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send(3*FFT_SIZE, 1'b0, 1'b0);
    step();
    checks++;
    if (LEVEL !== LW'(32) || DROP_FLAG !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill: got level=%0d drop=%b want 32 1", LEVEL, DROP_FLAG);
    end
    beat_log.delete();
    drain(1'b0, 100);
    checks++;
    if (beat_log.size() != 32) begin
      errors++;
      $display("FAIL ovf_count: got %0d want 32", beat_log.size());
    end
    for (int i = 0; i < beat_log.size(); i++) begin
      checks++;
      if (beat_log[i][2*AD] !== (i == 15 || i == 31)) begin
        errors++;
        $display("FAIL ovf_tlast%0d: got %b want %b", i, beat_log[i][2*AD], (i == 15 || i == 31));
      end
    end
  endtask

  task automatic test_toggle_ready();
    do_reset();
    beat_log.delete();
    send(FFT_SIZE, 1'b1, 1'b1);
    drain(1'b1, 200);
    M_TREADY = 1'b0;
    checks++;
    if (beat_log.size() != FFT_SIZE) begin
      errors++;
      $display("FAIL toggle_count: got %0d want %0d", beat_log.size(), FFT_SIZE);
    end
    for (int k = 0; k < beat_log.size(); k++) begin
      checks++;
      if (beat_log[k][AD-1:0] !== AD'(k) || beat_log[k][2*AD] !== (k == FFT_SIZE-1)) begin
        errors++;
        $display("FAIL toggle_beat%0d: got re=%0d last=%b want re=%0d last=%b",
                 k, beat_log[k][AD-1:0], beat_log[k][2*AD], k, (k == FFT_SIZE-1));
      end
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    beat_log.delete();
    M_TREADY = 1'b1;
    send(5, 1'b0, 1'b0);
    step();
    send(FFT_SIZE, 1'b0, 1'b0);
    drain(1'b0, 100);
    checks++;
    if (SHORT_FLAG !== 1'b1 || DROP_FLAG !== 1'b0) begin
      errors++;
      $display("FAIL short_flags: got short=%b drop=%b want 1 0", SHORT_FLAG, DROP_FLAG);
    end
    checks++;
    if (beat_log.size() != 21) begin
      errors++;
      $display("FAIL short_count: got %0d want 21", beat_log.size());
    end
    for (int i = 0; i < beat_log.size(); i++) begin
      checks++;
      if (beat_log[i][2*AD] !== (i == 20)) begin
        errors++;
        $display("FAIL short_tlast%0d: got %b want %b", i, beat_log[i][2*AD], (i == 20));
      end
    end
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    beat_log.delete();
    m_pushes = 0;
    thr = 2;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) thr = $urandom_range(0, 4);
      DATAO_VALID = ($urandom_range(0, 9) < 7);
      DATAO_RE = DB'($urandom);
      DATAO_IM = DB'($urandom);
      M_TREADY = ($urandom_range(0, 3) < thr);
      step();
    end
    drain(1'b0, 200);
    checks++;
    if (beat_log.size() != m_pushes) begin
      errors++;
      $display("FAIL random_count: got %0d beats want %0d", beat_log.size(), m_pushes);
    end
  endtask

  task automatic test_rst_mid_drain();
    bit found;
    do_reset();
    send(3, 1'b0, 1'b0);
    step();
    send(40, 1'b0, 1'b0);
    step();
    checks++;
    if (DROP_FLAG !== 1'b1 || SHORT_FLAG !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_flags_set: got drop=%b short=%b want 1 1", DROP_FLAG, SHORT_FLAG);
    end
    found = 1'b0;
    M_TREADY = 1'b1;
    for (int n = 0; n < 64; n++) begin
      step();
      if (LEVEL == 10) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_level10: got level=%0d want 10", LEVEL);
    end
    RST = 1'b1;
    step();
    checks++;
    if (M_TVALID !== 1'b0 || LEVEL !== '0 || DROP_FLAG !== 1'b0 || SHORT_FLAG !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: got tvalid=%b level=%0d drop=%b short=%b want 0 0 0 0",
               M_TVALID, LEVEL, DROP_FLAG, SHORT_FLAG);
    end
    RST = 1'b0;
    M_TREADY = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_toggle_ready();
    test_short_frame();
    test_random();
    test_rst_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
